// File: rtl/mypackage.sv
// Shared voice-path types and constants.
// frequency words are unsigned fixed point: hz << FREQUENCY_FRACTIONAL_BITS.
package mypackage;

  localparam int FREQUENCY_FRACTIONAL_BITS = 16;

  typedef logic [31:0] frequency;

endpackage

// File: rtl/key_gate.sv
// key_gate: conditions the raw push-buttons into the voice gate, trigger and
// note frequency word. Pipeline: 2-flop sync -> debounce -> gate FSM with
// octave retrigger -> octave select -> frequency word.
// Everything runs in the audio_clock domain.
// Build option: define KEY_GATE_LATCH_EN for latching gate mode (each key
// press toggles the note on/off). The default build is momentary.
module key_gate #(
  parameter int DEBOUNCE_CYCLES = 3840,
  parameter int RETRIG_CYCLES   = 2,
  parameter int BASE_HZ         = 440
) (
  input  logic                 audio_clock,
  input  logic                 reset,
  input  logic                 key_n,
  input  logic                 octave_n,
  output logic                 gate,
  output logic                 trigger,
  output logic                 octave,
  output mypackage::frequency  freq
);

  import mypackage::*;

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int RCNT_W = (RETRIG_CYCLES > 1) ? $clog2(RETRIG_CYCLES) : 1;

  // Both note words are constants; the octave only selects between them.
  localparam frequency FREQ_LO = frequency'(BASE_HZ) << FREQUENCY_FRACTIONAL_BITS;
  localparam frequency FREQ_HI = frequency'(2 * BASE_HZ) << FREQUENCY_FRACTIONAL_BITS;

  localparam int KEY = 0;
  localparam int OCT = 1;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    RETRIG
  } state_t;

  // Bit KEY is the gate button, bit OCT the octave button; all active-low.
  logic [1:0]       raw_n;
  logic [1:0]       sync_1;
  logic [1:0]       sync_2;
  logic [1:0]       stable;
  logic [1:0]       stable_d;
  logic [CNT_W-1:0] cnt [2];

  logic             press_k;
  logic             press_o;
  logic             end_note;

  state_t           state;
  logic [RCNT_W-1:0] rcnt;

  assign raw_n = {octave_n, key_n};

  // Two-flop synchronisers; released (1) out of reset so no false press.
  // NOTE: every clocked block uses <= so all flops sample pre-edge values together.
  // NOTE: reset is asynchronous and forces outputs immediately, independent of the clock.
  always_ff @(posedge audio_clock or posedge reset) begin
    if (reset) begin
      sync_1 <= 2'b11;
      sync_2 <= 2'b11;
    end else begin
      sync_1 <= raw_n;
      sync_2 <= sync_1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive samples of it.
  always_ff @(posedge audio_clock or posedge reset) begin
    if (reset) begin
      stable <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync_2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Delayed copy of the debounced levels for one-cycle edge detection.
  always_ff @(posedge audio_clock or posedge reset) begin
    if (reset) begin
      stable_d <= 2'b11;
    end else begin
      stable_d <= stable;
    end
  end

  assign press_k = stable_d[KEY] & ~stable[KEY];
  assign press_o = stable_d[OCT] & ~stable[OCT];

`ifdef KEY_GATE_LATCH_EN
  // Latching: a second key press ends the note; key release carries no meaning.
  assign end_note = press_k;
`else
  // Momentary: the note lasts while the key is held.
  assign end_note = ~stable_d[KEY] & stable[KEY];
`endif

  // Gate FSM: gate high only in HELD; trigger pulses on every entry to HELD.
  always_ff @(posedge audio_clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rcnt    <= '0;
      gate    <= 1'b0;
      trigger <= 1'b0;
    end else begin
      // NOTE: trigger defaults low each cycle so any set below is a single-cycle pulse.
      trigger <= 1'b0;
      case (state)
        IDLE: begin
          if (press_k) begin
            state   <= HELD;
            gate    <= 1'b1;
            trigger <= 1'b1;
          end
        end
        HELD: begin
          // Ending the note takes priority over an octave retrigger.
          if (end_note) begin
            state <= IDLE;
            gate  <= 1'b0;
          end else if (press_o) begin
            state <= RETRIG;
            gate  <= 1'b0;
            rcnt  <= '0;
          end
        end
        RETRIG: begin
          if (end_note) begin
            state <= IDLE;
            gate  <= 1'b0;
          end else if (rcnt == RCNT_W'(RETRIG_CYCLES - 1)) begin
            state   <= HELD;
            gate    <= 1'b1;
            trigger <= 1'b1;
          end else begin
            rcnt <= rcnt + RCNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          gate  <= 1'b0;
        end
      endcase
    end
  end

  // Octave toggles on each debounced octave press; its release is ignored.
  always_ff @(posedge audio_clock or posedge reset) begin
    if (reset) begin
      octave <= 1'b0;
    end else if (press_o) begin
      octave <= ~octave;
    end
  end

  // Frequency word follows the octave one cycle later.
  always_ff @(posedge audio_clock or posedge reset) begin
    if (reset) begin
      freq <= FREQ_LO;
    end else begin
      freq <= octave ? FREQ_HI : FREQ_LO;
    end
  end

endmodule
